// File: rtl/sa_seq_ctrl_pkg.sv
// sa_seq_ctrl_pkg: shared FSM state encoding and drain-length formula for the array sequencer
package sa_seq_ctrl_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Cycles for the last operand to cross the skew, the array diagonal and the array pipeline
    function automatic int drain_cyc(input int hpe, input int vpe, input int pipe_lat);
        return 1 + (hpe - 1) + (vpe - 1) + pipe_lat;
    endfunction

endpackage

// File: rtl/sa_seq_ctrl_if.sv
// sa_seq_ctrl_if: control, operand-buffer and array-side signals of the sequencer
interface sa_seq_ctrl_if #(
    parameter int HPE   = 4,
    parameter int VPE   = 4,
    parameter int WIDTH = 16,
    parameter int KW    = 8
);
    logic                 start;
    logic                 abort;
    logic [KW-1:0]        k_len;
    logic                 busy;
    logic                 done;
    logic                 rd_en;
    logic [KW-1:0]        rd_addr;
    logic [WIDTH*HPE-1:0] a_rdata;
    logic [WIDTH*VPE-1:0] b_rdata;
    logic [WIDTH*HPE-1:0] sa_a;
    logic [WIDTH*VPE-1:0] sa_b;
    logic                 sa_clr;
    logic                 res_valid;

    modport master (
        input  start, abort, k_len, a_rdata, b_rdata,
        output busy, done, rd_en, rd_addr, sa_a, sa_b, sa_clr, res_valid
    );

    modport slave (
        output start, abort, k_len, a_rdata, b_rdata,
        input  busy, done, rd_en, rd_addr, sa_a, sa_b, sa_clr, res_valid
    );
endinterface

// File: rtl/sa_seq_ctrl_skew.sv
// sa_skew_line: triangular delay line, lane n delayed n cycles, zero-injected when data is not valid
module sa_skew_line #(
    parameter int LANES = 4,
    parameter int WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_vld,
    input  logic [WIDTH*LANES-1:0] i_data,
    output logic [WIDTH*LANES-1:0] o_data
);
    for (genvar n = 0; n < LANES; n++) begin : g_lane
        logic [WIDTH-1:0] w_in;
        assign w_in = i_vld ? i_data[n*WIDTH +: WIDTH] : '0;
        if (n == 0) begin : g_thru
            assign o_data[WIDTH-1:0] = w_in;
        end else begin : g_dly
            logic [WIDTH-1:0] r_d [n];
            // shift chain of n stages; flush wipes in-flight operands on abort
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst || i_flush) begin
                    for (int k = 0; k < n; k++) r_d[k] <= '0;
                end else begin
                    r_d[0] <= w_in;
                    for (int k = 1; k < n; k++) r_d[k] <= r_d[k-1];
                end
            end
            assign o_data[n*WIDTH +: WIDTH] = r_d[n-1];
        end
    end
endmodule

// File: rtl/sa_seq_ctrl.sv
// sa_seq_ctrl: sequences one clear/feed/drain pass of the 2D systolic array with operand skew
module sa_seq_ctrl
    import sa_seq_ctrl_pkg::*;
#(
    parameter int HPE      = 4,
    parameter int VPE      = 4,
    parameter int WIDTH    = 16,
    parameter int KW       = 8,
    parameter int PIPE_LAT = 2
) (
    input logic            i_clk,
    input logic            i_rst,
    sa_seq_ctrl_if.master  bus
);
    localparam int DRAIN_CYC = drain_cyc(HPE, VPE, PIPE_LAT);
    localparam int DW        = $clog2(DRAIN_CYC + 1);

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [KW-1:0] r_klen;
    logic [KW-1:0] r_feed_cnt;
    logic [DW-1:0] r_drain_cnt;
    logic          r_aborted;
    logic          r_rd_vld;
    logic          w_abort;
    logic          w_rd_en;
    logic          w_feed_last;
    logic          w_drain_last;

    assign w_abort      = bus.abort && (r_state == S_CLEAR || r_state == S_FEED || r_state == S_DRAIN);
    assign w_rd_en      = r_state == S_FEED;
    assign w_feed_last  = r_feed_cnt == r_klen - KW'(1);
    assign w_drain_last = r_drain_cnt == DW'(DRAIN_CYC - 1);

    // next state; abort overrides every normal transition of the active states
    always_comb begin
        w_next = w_abort                ? S_DONE :
                 (r_state == S_IDLE)    ? (bus.start ? S_CLEAR : S_IDLE) :
                 (r_state == S_CLEAR)   ? ((r_klen != '0) ? S_FEED : S_DONE) :
                 (r_state == S_FEED)    ? (w_feed_last ? S_DRAIN : S_FEED) :
                 (r_state == S_DRAIN)   ? (w_drain_last ? S_DONE : S_DRAIN) : S_IDLE;
    end

    // state, latched pass length, abort memory and read-data-valid tracking
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_klen    <= '0;
            r_aborted <= 1'b0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_rd_vld <= w_rd_en && !w_abort;
            if (r_state == S_IDLE && bus.start) begin
                r_klen    <= bus.k_len;
                r_aborted <= 1'b0;
            end else if (w_abort) begin
                r_aborted <= 1'b1;
            end
        end
    end

    // feed address and drain counters, parked at zero outside their states
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_feed_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_feed_cnt  <= (w_rd_en && !w_feed_last && !w_abort) ? r_feed_cnt + KW'(1) : '0;
            r_drain_cnt <= (r_state == S_DRAIN && !w_drain_last && !w_abort) ? r_drain_cnt + DW'(1) : '0;
        end
    end

    assign bus.busy      = r_state != S_IDLE;
    assign bus.done      = r_state == S_DONE;
    assign bus.res_valid = r_state == S_DONE && !r_aborted;
    assign bus.sa_clr    = r_state == S_CLEAR;
    assign bus.rd_en     = w_rd_en;
    assign bus.rd_addr   = r_feed_cnt;

    sa_skew_line #(.LANES(HPE), .WIDTH(WIDTH)) u_skew_a (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (w_abort),
        .i_vld   (r_rd_vld),
        .i_data  (bus.a_rdata),
        .o_data  (bus.sa_a)
    );

    sa_skew_line #(.LANES(VPE), .WIDTH(WIDTH)) u_skew_b (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (w_abort),
        .i_vld   (r_rd_vld),
        .i_data  (bus.b_rdata),
        .o_data  (bus.sa_b)
    );
endmodule

// File: tb/tb_sa_seq_ctrl.sv
// tb_sa_seq_ctrl: randomized self-checking bench against a cycle-offset timeline model and a PE dot-product scoreboard
module tb_sa_seq_ctrl;
    localparam int HPE   = 4;
    localparam int VPE   = 4;
    localparam int WIDTH = 16;
    localparam int KW    = 8;
    localparam int PLAT  = 2;
    localparam int DRAIN = 1 + (HPE - 1) + (VPE - 1) + PLAT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sa_seq_ctrl_if #(.HPE(HPE), .VPE(VPE), .WIDTH(WIDTH), .KW(KW)) bus ();

    sa_seq_ctrl #(.HPE(HPE), .VPE(VPE), .WIDTH(WIDTH), .KW(KW), .PIPE_LAT(PLAT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] amem [256][HPE];
    logic [WIDTH-1:0] bmem [256][VPE];
    logic [WIDTH-1:0] cap_a [HPE][400];
    logic [WIDTH-1:0] cap_b [VPE][400];
    logic             pre_en;
    logic [KW-1:0]    pre_addr;

    // one clock: the operand buffer answers a read one cycle later, otherwise shows garbage
    task automatic step();
        pre_en   = bus.rd_en;
        pre_addr = bus.rd_addr;
        @(posedge clk);
        #1;
        for (int i = 0; i < HPE; i++) bus.a_rdata[i*WIDTH +: WIDTH] = pre_en ? amem[pre_addr][i] : WIDTH'($urandom);
        for (int j = 0; j < VPE; j++) bus.b_rdata[j*WIDTH +: WIDTH] = pre_en ? bmem[pre_addr][j] : WIDTH'($urandom);
        #1;
    endtask

    // runs one pass, start sampled in offset 0; da = abort offset (<=0 none); stop = early return offset
    task automatic run_pass(input int k, input bit ones, input int da, input int stop, input bit hold, input bit noise, input string tag);
        int dd, last, ai;
        bit ab;
        logic [12:0] ectl, actl;
        logic [WIDTH*HPE-1:0] ea;
        logic [WIDTH*VPE-1:0] eb;
        logic [63:0] pe, epe;
        dd   = (k == 0) ? 2 : k + 2 + DRAIN;
        last = (da > 0) ? da + 2 : dd + 1;
        for (int a = 0; a < 256; a++) begin
            for (int i = 0; i < HPE; i++) amem[a][i] = ones ? WIDTH'(1) : WIDTH'($urandom);
            for (int j = 0; j < VPE; j++) bmem[a][j] = ones ? WIDTH'(1) : WIDTH'($urandom);
        end
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < HPE; i++) cap_a[i][t] = '0;
            for (int j = 0; j < VPE; j++) cap_b[j][t] = '0;
        end
        bus.k_len = KW'(k);
        bus.start = 1'b1;
        bus.abort = noise ? 1'($urandom) : 1'b0;
        for (int d = 1; d <= last; d++) begin
            step();
            ab = (da > 0) && (d > da);
            if (ab) ectl = {d == da + 1, 1'b0, 1'b0, 8'd0, d == da + 1, 1'b0};
            else begin
                ectl[12]  = d <= dd;
                ectl[11]  = d == 1;
                ectl[10]  = k > 0 && d >= 2 && d <= k + 1;
                ectl[9:2] = ectl[10] ? KW'(d - 2) : '0;
                ectl[1]   = d == dd;
                ectl[0]   = d == dd;
            end
            actl = {bus.busy, bus.sa_clr, bus.rd_en, bus.rd_addr, bus.done, bus.res_valid};
            checks++;
            if (actl !== ectl) begin
                errors++;
                $display("FAIL %s ctrl d=%0d got busy/clr/en/addr/done/rv=%b expected %b", tag, d, actl, ectl);
            end
            for (int i = 0; i < HPE; i++) begin
                ai = d - 3 - i;
                ea[i*WIDTH +: WIDTH] = (!ab && ai >= 0 && ai < k) ? amem[ai][i] : '0;
                cap_a[i][d] = bus.sa_a[i*WIDTH +: WIDTH];
            end
            for (int j = 0; j < VPE; j++) begin
                ai = d - 3 - j;
                eb[j*WIDTH +: WIDTH] = (!ab && ai >= 0 && ai < k) ? bmem[ai][j] : '0;
                cap_b[j][d] = bus.sa_b[j*WIDTH +: WIDTH];
            end
            checks++;
            if (bus.sa_a !== ea) begin
                errors++;
                $display("FAIL %s sa_a d=%0d got %h expected %h", tag, d, bus.sa_a, ea);
            end
            checks++;
            if (bus.sa_b !== eb) begin
                errors++;
                $display("FAIL %s sa_b d=%0d got %h expected %h", tag, d, bus.sa_b, eb);
            end
            if (d == stop) return;
            bus.start = hold ? 1'b1 : (noise && d <= dd) ? 1'($urandom) : 1'b0;
            bus.k_len = (noise && d <= dd) ? KW'($urandom) : KW'(k);
            bus.abort = (d == da) ? 1'b1 : (noise && d == dd) ? 1'($urandom) : 1'b0;
        end
        bus.abort = 1'b0;
        if (da > 0) return;
        for (int i = 0; i < HPE; i++) begin
            for (int j = 0; j < VPE; j++) begin
                pe  = '0;
                epe = '0;
                for (int t = 0; t < 400; t++)
                    if (t - j >= 0 && t - i >= 0) pe += 64'(cap_a[i][t-j]) * 64'(cap_b[j][t-i]);
                for (int a = 0; a < k; a++) epe += 64'(amem[a][i]) * 64'(bmem[a][j]);
                checks++;
                if (pe !== epe) begin
                    errors++;
                    $display("FAIL %s pe[%0d][%0d] got %0d expected %0d", tag, i, j, pe, epe);
                end
            end
        end
    endtask

    task automatic test_reset();
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.k_len   = '0;
        bus.a_rdata = {HPE{WIDTH'($urandom)}};
        bus.b_rdata = {VPE{WIDTH'($urandom)}};
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.sa_clr, bus.res_valid} !== 13'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 0", {bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.sa_clr, bus.res_valid});
        end
        checks++;
        if (bus.sa_a !== '0 || bus.sa_b !== '0) begin
            errors++;
            $display("FAIL reset_sa got a=%h b=%h expected 0", bus.sa_a, bus.sa_b);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.sa_a !== '0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b sa_a=%h expected 0", bus.busy, bus.sa_a);
        end
    endtask

    task automatic test_nominal();
        run_pass(4, 1'b1, 0, -1, 1'b0, 1'b0, "nominal");
    endtask

    task automatic test_skew();
        run_pass(7, 1'b0, 0, -1, 1'b0, 1'b0, "skew_rand");
        run_pass(1, 1'b0, 0, -1, 1'b0, 1'b0, "skew_k1");
    endtask

    task automatic test_zero_len();
        run_pass(0, 1'b0, 0, -1, 1'b0, 1'b0, "zero_len");
    endtask

    task automatic test_abort();
        run_pass(10, 1'b0, 4, -1, 1'b0, 1'b0, "abort_feed");
        run_pass(5, 1'b0, 1, -1, 1'b0, 1'b0, "abort_clear");
        run_pass(3, 1'b0, 10, -1, 1'b0, 1'b0, "abort_drain");
    endtask

    task automatic test_back_to_back();
        run_pass(2, 1'b0, 0, -1, 1'b1, 1'b0, "b2b_1");
        run_pass(2, 1'b0, 0, -1, 1'b1, 1'b0, "b2b_2");
        run_pass(2, 1'b0, 0, -1, 1'b0, 1'b0, "b2b_3");
    endtask

    task automatic test_noise();
        for (int n = 0; n < 4; n++) run_pass(int'($urandom_range(0, 20)), 1'b0, 0, -1, 1'b0, 1'b1, "noise");
    endtask

    task automatic test_max_len();
        run_pass(255, 1'b0, 0, -1, 1'b0, 1'b0, "max_len");
    endtask

    task automatic test_async_reset();
        int seen;
        run_pass(3, 1'b0, 0, 8, 1'b0, 1'b0, "pre_reset");
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.rd_en, bus.done, bus.res_valid, bus.sa_clr} !== 5'd0 || bus.sa_a !== '0 || bus.sa_b !== '0) begin
            errors++;
            $display("FAIL async_reset got busy=%b rd_en=%b done=%b sa_a=%h sa_b=%h expected 0", bus.busy, bus.rd_en, bus.done, bus.sa_a, bus.sa_b);
        end
        #1 rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (bus.done || bus.res_valid || bus.busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL post_reset_quiet got %0d active cycles expected 0", seen);
        end
        run_pass(5, 1'b0, 0, -1, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_skew();
        test_zero_len();
        test_abort();
        test_back_to_back();
        test_noise();
        test_max_len();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
